fifo_packer: RTL

Downstream consumer for the team's byte FIFOs (shift and ring variants). It pops DATA_WIDTH-bit entries through the FIFO's val/read interface and assembles RATIO consecutive entries into one wide word. The word is presented on a valid/ready output port. A flush request emits a partially filled word, which lets packet tails drain without waiting for more input.

---
 rtl/fifo_packer_if.sv | 35 +++
 rtl/fifo_packer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fifo_packer_if.sv
// fifo_packer_if: handshake bundle between a byte FIFO, the packer and the
// downstream word consumer.
//   FIFO side  : in_val, in_data (show-ahead), in_read (pop strobe)
//   Control    : flush (single-cycle partial-word request), idle (status)
//   Word side  : out_valid, out_ready, out_data, out_count
// Modports:
//   slave  - the packer itself (consumes FIFO entries, produces words)
//   master - the environment (FIFO + downstream consumer)
interface fifo_packer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 4
);
    localparam int unsigned OUT_WIDTH = DATA_WIDTH * RATIO;
    localparam int unsigned CNT_W     = $clog2(RATIO) + 1;

    logic                  in_val;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_read;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic [CNT_W-1:0]      out_count;
    logic                  idle;

    modport slave (
        input  in_val, in_data, flush, out_ready,
        output in_read, out_valid, out_data, out_count, idle
    );

    modport master (
        output in_val, in_data, flush, out_ready,
        input  in_read, out_valid, out_data, out_count, idle
    );
endinterface

// File: rtl/fifo_packer.sv
// fifo_packer: pops DATA_WIDTH-bit entries from a show-ahead FIFO and packs
// RATIO consecutive entries into one OUT_WIDTH-bit word on a valid/ready
// port. A flush pulse emits the partially filled word (unfilled lanes zero).
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   bus    - fifo_packer_if.slave: in_val/in_data/in_read (FIFO side),
//            flush, out_valid/out_ready/out_data/out_count (word side), idle
//
// Build option:
//   FIFO_PACKER_MSB_FIRST_EN - when defined, lane 0 is placed at the top of
//   out_data instead of the bottom; partial-word padding moves to low lanes.
module fifo_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 4
) (
    input  logic            clk,
    input  logic            reset,
    fifo_packer_if.slave    bus
);
    localparam int unsigned OUT_WIDTH = DATA_WIDTH * RATIO;
    localparam int unsigned CNT_W     = $clog2(RATIO) + 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RATIO);

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [OUT_WIDTH-1:0]  acc_q,       acc_d;
    logic [OUT_WIDTH-1:0]  out_data_q,  out_data_d;
    logic [CNT_W-1:0]      out_count_q, out_count_d;
    logic                  out_valid_q, out_valid_d;

    logic                  slot_free;
    logic                  pop;
    logic [OUT_WIDTH-1:0]  merged;

    // Bit offset of lane c inside the packed word.
    function automatic int unsigned lane_shift(input logic [CNT_W-1:0] c);
`ifdef FIFO_PACKER_MSB_FIRST_EN
        return (RATIO - 1 - 32'(c)) * DATA_WIDTH;
`else
        return 32'(c) * DATA_WIDTH;
`endif
    endfunction

    assign slot_free = !out_valid_q || bus.out_ready;

    // The last lane may only be popped if the completed word has somewhere
    // to go; earlier lanes only land in acc and are never blocked. Gated by
    // reset so the FIFO is never popped while the packer is held in reset.
    assign pop = reset && bus.in_val && (state_q == FILL) && !bus.flush &&
                 ((cnt_q != LAST_LANE) || slot_free);

    // Target lane in acc is always zero (acc is cleared on every word),
    // so OR-merging is equivalent to a lane write.
    assign merged = acc_q |
        ({{(OUT_WIDTH - DATA_WIDTH){1'b0}}, bus.in_data} << lane_shift(cnt_q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            FILL: begin
                if (bus.flush) begin
                    state_d = FLUSH;
                end else if (pop) begin
                    if (cnt_q != LAST_LANE) begin
                        acc_d = merged;
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        out_data_d  = merged;
                        out_count_d = FULL_CNT;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = FILL;
                end else if (slot_free) begin
                    out_data_d  = acc_q;
                    out_count_d = cnt_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_read   = pop;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.idle      = (cnt_q == '0) && (state_q == FILL) && !out_valid_q;

endmodule
